// File: rtl/mem_req_sched_pkg.sv
// Shared memory-side definitions: size codes, owner IDs, FSM encodings.
package mycpu_mem_pkg;

   localparam logic [2:0] SZ_BYTE = 3'b000;
   localparam logic [2:0] SZ_HALF = 3'b001;
   localparam logic [2:0] SZ_WORD = 3'b010;
   localparam logic [2:0] SZ_LINE = 3'b100;

   localparam logic ID_INST = 1'b0;
   localparam logic ID_DATA = 1'b1;

   typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT} rd_state_e;
   typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT} wr_state_e;

   // Number of return beats the bridge owes for a given size code.
   function automatic logic [2:0] exp_beats(input logic [2:0] sz);
      return (sz == SZ_LINE) ? 3'd4 : 3'd1;
   endfunction

endpackage

// File: rtl/mem_req_sched_if.sv
// Cache-side and bridge-side buses of the request scheduler.
// slave = scheduler view, master = requesters/bridge view.
interface mem_req_sched_if;
   logic        i_rd_req;
   logic [2:0]  i_rd_type;
   logic [31:0] i_rd_addr;
   logic        i_rd_rdy;
   logic        i_ret_valid;
   logic        i_ret_last;
   logic [31:0] i_ret_data;

   logic        d_rd_req;
   logic [2:0]  d_rd_type;
   logic [31:0] d_rd_addr;
   logic        d_rd_rdy;
   logic        d_ret_valid;
   logic        d_ret_last;
   logic [31:0] d_ret_data;

   logic        d_wr_req;
   logic [2:0]  d_wr_type;
   logic [31:0] d_wr_addr;
   logic [3:0]  d_wr_wstrb;
   logic [127:0] d_wr_data;
   logic        d_wr_rdy;

   logic        b_rd_req;
   logic        b_rd_id;
   logic [2:0]  b_rd_type;
   logic [31:0] b_rd_addr;
   logic        b_rd_rdy;
   logic        b_ret_valid;
   logic        b_ret_last;
   logic [31:0] b_ret_data;

   logic        b_wr_req;
   logic [2:0]  b_wr_type;
   logic [31:0] b_wr_addr;
   logic [3:0]  b_wr_wstrb;
   logic [127:0] b_wr_data;
   logic        b_wr_rdy;
   logic        b_wr_done;

   modport slave (
      input  i_rd_req, i_rd_type, i_rd_addr,
      output i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
      input  d_rd_req, d_rd_type, d_rd_addr,
      output d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
      input  d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
      output d_wr_rdy,
      output b_rd_req, b_rd_id, b_rd_type, b_rd_addr,
      input  b_rd_rdy, b_ret_valid, b_ret_last, b_ret_data,
      output b_wr_req, b_wr_type, b_wr_addr, b_wr_wstrb, b_wr_data,
      input  b_wr_rdy, b_wr_done
   );

   modport master (
      output i_rd_req, i_rd_type, i_rd_addr,
      input  i_rd_rdy, i_ret_valid, i_ret_last, i_ret_data,
      output d_rd_req, d_rd_type, d_rd_addr,
      input  d_rd_rdy, d_ret_valid, d_ret_last, d_ret_data,
      output d_wr_req, d_wr_type, d_wr_addr, d_wr_wstrb, d_wr_data,
      input  d_wr_rdy,
      input  b_rd_req, b_rd_id, b_rd_type, b_rd_addr,
      output b_rd_rdy, b_ret_valid, b_ret_last, b_ret_data,
      input  b_wr_req, b_wr_type, b_wr_addr, b_wr_wstrb, b_wr_data,
      output b_wr_rdy, b_wr_done
   );
endinterface

// File: rtl/mem_req_sched_rd_arbiter.sv
// Read-port winner selection: data priority with starvation guard for inst,
// data reads blocked while they hit the line of an in-flight write.
import mycpu_mem_pkg::*;

module rd_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int LINE_OFS     = 4
) (
   input  logic                clk,
   input  logic                aresetn,
   input  logic                i_idle,
   input  logic                i_inst_req,
   input  logic                i_data_req,
   input  logic [31-LINE_OFS:0] i_data_line,
   input  logic                i_wr_busy,
   input  logic [31-LINE_OFS:0] i_wr_line,
   output logic                o_inst_gnt,
   output logic                o_data_gnt
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic [CW-1:0] r_starve_cnt;
   logic          w_hazard;
   logic          w_data_ok;
   logic          w_starved;

   assign w_hazard   = i_wr_busy && (i_data_line == i_wr_line);
   assign w_data_ok  = i_data_req && !w_hazard;
   assign w_starved  = (r_starve_cnt == CW'(STARVE_LIMIT));
   // A blocked data read falls through to inst; a starved inst beats data.
   assign o_inst_gnt = i_idle && i_inst_req && (!w_data_ok || w_starved);
   assign o_data_gnt = i_idle && w_data_ok && !(i_inst_req && w_starved);

   // Count data grants that jumped a waiting inst read, saturating.
   always_ff @(posedge clk) begin
      if (!aresetn)                      r_starve_cnt <= '0;
      else if (!i_inst_req || o_inst_gnt) r_starve_cnt <= '0;
      else if (o_data_gnt && !w_starved)  r_starve_cnt <= r_starve_cnt + CW'(1);
   end
endmodule

// File: rtl/mem_req_sched.sv
// Scheduler between I$/D$ and the single-port bridge front end:
// one outstanding read (arbitrated) plus one outstanding write.
import mycpu_mem_pkg::*;

module mem_req_sched #(
   parameter int STARVE_LIMIT = 4,
   parameter int LINE_OFS     = 4
) (
   input  logic            clk,
   input  logic            aresetn,
   mem_req_sched_if.slave  bus,
   output logic            proto_err
);
   rd_state_e    r_rd_state, w_rd_state_nxt;
   wr_state_e    r_wr_state, w_wr_state_nxt;
   logic [2:0]   r_rd_type;
   logic [31:0]  r_rd_addr;
   logic         r_rd_id;
   logic [2:0]   r_beat_cnt;
   logic [2:0]   r_wr_type;
   logic [31:0]  r_wr_addr;
   logic [3:0]   r_wr_wstrb;
   logic [127:0] r_wr_data;
   logic         r_proto_err;

   logic w_inst_gnt, w_data_gnt, w_gnt;
   logic w_fwd, w_len_err, w_rd_stray, w_wr_stray;

   rd_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .LINE_OFS(LINE_OFS)) u_arb (
      .clk         (clk),
      .aresetn     (aresetn),
      .i_idle      (r_rd_state == R_IDLE),
      .i_inst_req  (bus.i_rd_req),
      .i_data_req  (bus.d_rd_req),
      .i_data_line (bus.d_rd_addr[31:LINE_OFS]),
      .i_wr_busy   (r_wr_state != W_IDLE),
      .i_wr_line   (r_wr_addr[31:LINE_OFS]),
      .o_inst_gnt  (w_inst_gnt),
      .o_data_gnt  (w_data_gnt)
   );

   assign w_gnt      = w_inst_gnt || w_data_gnt;
   assign w_fwd      = aresetn && (r_rd_state == R_WAIT) && bus.b_ret_valid;
   assign w_len_err  = w_fwd && bus.b_ret_last && ((r_beat_cnt + 3'd1) != exp_beats(r_rd_type));
   assign w_rd_stray = bus.b_ret_valid && (r_rd_state != R_WAIT);
   assign w_wr_stray = bus.b_wr_done && (r_wr_state != W_WAIT);

   // Read FSM next state.
   always_comb begin
      w_rd_state_nxt = r_rd_state;
      case (r_rd_state)
         R_IDLE:  if (w_gnt) w_rd_state_nxt = R_REQ;
         R_REQ:   if (bus.b_rd_rdy) w_rd_state_nxt = R_WAIT;
         R_WAIT:  if (bus.b_ret_valid && bus.b_ret_last) w_rd_state_nxt = R_IDLE;
         default: w_rd_state_nxt = R_IDLE;
      endcase
   end

   // Write FSM next state.
   always_comb begin
      w_wr_state_nxt = r_wr_state;
      case (r_wr_state)
         W_IDLE:  if (bus.d_wr_req) w_wr_state_nxt = W_REQ;
         W_REQ:   if (bus.b_wr_rdy) w_wr_state_nxt = W_WAIT;
         W_WAIT:  if (bus.b_wr_done) w_wr_state_nxt = W_IDLE;
         default: w_wr_state_nxt = W_IDLE;
      endcase
   end

   // Read state, latched winner request and beat counter.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         r_rd_state <= R_IDLE;
         r_rd_type  <= '0;
         r_rd_addr  <= '0;
         r_rd_id    <= ID_INST;
         r_beat_cnt <= '0;
      end else begin
         r_rd_state <= w_rd_state_nxt;
         if (w_gnt) begin
            r_rd_id   <= w_data_gnt ? ID_DATA : ID_INST;
            r_rd_type <= w_data_gnt ? bus.d_rd_type : bus.i_rd_type;
            r_rd_addr <= w_data_gnt ? bus.d_rd_addr : bus.i_rd_addr;
         end
         if (r_rd_state == R_REQ && bus.b_rd_rdy) r_beat_cnt <= '0;
         else if (w_fwd)                          r_beat_cnt <= r_beat_cnt + 3'd1;
      end
   end

   // Write state and registered copy of the accepted write.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         r_wr_state <= W_IDLE;
         r_wr_type  <= '0;
         r_wr_addr  <= '0;
         r_wr_wstrb <= '0;
         r_wr_data  <= '0;
      end else begin
         r_wr_state <= w_wr_state_nxt;
         if (r_wr_state == W_IDLE && bus.d_wr_req) begin
            r_wr_type  <= bus.d_wr_type;
            r_wr_addr  <= bus.d_wr_addr;
            r_wr_wstrb <= bus.d_wr_wstrb;
            r_wr_data  <= bus.d_wr_data;
         end
      end
   end

   // Sticky protocol error: bad beat count, stray beat or stray write response.
   always_ff @(posedge clk) begin
      if (!aresetn)                               r_proto_err <= 1'b0;
      else if (w_len_err || w_rd_stray || w_wr_stray) r_proto_err <= 1'b1;
   end

   // Ready strobes are held low while reset is asserted.
   assign bus.i_rd_rdy   = aresetn && w_inst_gnt;
   assign bus.d_rd_rdy   = aresetn && w_data_gnt;
   assign bus.d_wr_rdy   = aresetn && (r_wr_state == W_IDLE);

   assign bus.b_rd_req   = (r_rd_state == R_REQ);
   assign bus.b_rd_id    = r_rd_id;
   assign bus.b_rd_type  = r_rd_type;
   assign bus.b_rd_addr  = r_rd_addr;

   // Return steering: only the owner sees the beat, the other port reads zero.
   assign bus.i_ret_valid = w_fwd && (r_rd_id == ID_INST);
   assign bus.i_ret_last  = bus.i_ret_valid && bus.b_ret_last;
   assign bus.i_ret_data  = bus.i_ret_valid ? bus.b_ret_data : '0;
   assign bus.d_ret_valid = w_fwd && (r_rd_id == ID_DATA);
   assign bus.d_ret_last  = bus.d_ret_valid && bus.b_ret_last;
   assign bus.d_ret_data  = bus.d_ret_valid ? bus.b_ret_data : '0;

   assign bus.b_wr_req   = (r_wr_state == W_REQ);
   assign bus.b_wr_type  = r_wr_type;
   assign bus.b_wr_addr  = r_wr_addr;
   assign bus.b_wr_wstrb = r_wr_wstrb;
   assign bus.b_wr_data  = r_wr_data;

   assign proto_err = r_proto_err;
endmodule
